acm_rx_fifo: RTL and testbench

- Byte-wide elastic buffer between the MUACM host-to-device stream and the CPU system's USB ACIA receive port (rx_data/rx_val/rx_rdy).
- Absorbs USB packet bursts: up to 64 bytes at one byte per clock, while firmware drains slowly.
- Provides fill-level and watermark status.
- First-word-fall-through output with a valid/ready handshake on both sides.

---
 rtl/acm_rx_fifo.sv | 140 ++++++++++++++
 tb/tb_acm_rx_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/acm_rx_fifo.sv
// Byte elastic buffer from the MUACM host-to-device stream to the ACIA receive port.
// Latency: a byte written into an empty buffer is presented two edges after acceptance.
// Backpressure: s_rdy drops only at level==DEPTH; FWFT output holds until m_rdy.
module acm_rx_fifo #(
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int HIWATER = 192
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [7:0]    s_data,
  input  logic          s_val,
  output logic          s_rdy,
  output logic [7:0]    m_data,
  output logic          m_val,
  input  logic          m_rdy,
  output logic [AW:0]   level,
  output logic          hiwater,
  output logic          ovf
);

  localparam logic [AW:0] DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [AW:0] HIWATER_L = (AW+1)'(HIWATER);

  logic [7:0]    mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          pf_vld_q, pf_vld_d;
  logic [7:0]    pf_dat_q;
  logic          m_val_q, m_val_d;
  logic [7:0]    m_data_q, m_data_d;
  logic [AW:0]   level_q, level_d;
  logic          s_rdy_q, s_rdy_d;
  logic          hiwater_q, hiwater_d;
  logic          ovf_q, ovf_d;

  logic          clr;
  logic          wr_en;
  logic          rd_xfer;
  logic          out_load;
  logic          mem_rd;
  logic [AW:0]   mem_cnt;

  // Transfer qualifiers; bytes still in RAM are the level minus the prefetch and output stages.
  always_comb begin
    clr      = rst | flush;
    wr_en    = s_val & s_rdy_q & ~clr;
    rd_xfer  = m_val_q & m_rdy & ~clr;
    out_load = pf_vld_q & (~m_val_q | m_rdy);
    mem_cnt  = level_q - (AW+1)'(pf_vld_q) - (AW+1)'(m_val_q);
    mem_rd   = (mem_cnt != '0) & (~pf_vld_q | out_load) & ~clr;
  end

  // Next-state for pointers, prefetch/output stages and status; flush clears like reset.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pf_vld_d  = pf_vld_q;
    m_val_d   = m_val_q;
    m_data_d  = m_data_q;
    level_d   = level_q;
    ovf_d     = ovf_q;

    if (wr_en)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (mem_rd) rd_ptr_d = rd_ptr_q + 1'b1;

    // Prefetch stage fills on a RAM read and empties when it moves to the output.
    if (mem_rd)        pf_vld_d = 1'b1;
    else if (out_load) pf_vld_d = 1'b0;

    if (out_load) begin
      m_val_d  = 1'b1;
      m_data_d = pf_dat_q;
    end else if (m_rdy) begin
      m_val_d  = 1'b0;
    end

    case ({wr_en, rd_xfer})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (s_val & ~s_rdy_q) ovf_d = 1'b1;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      pf_vld_d = 1'b0;
      m_val_d  = 1'b0;
      m_data_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end

    s_rdy_d   = (level_d < DEPTH_L);
    hiwater_d = (level_d >= HIWATER_L);
  end

  // Block RAM: write port plus registered read into the prefetch stage.
  always_ff @(posedge clk) begin
    if (wr_en)  mem[wr_ptr_q] <= s_data;
    if (mem_rd) pf_dat_q      <= mem[rd_ptr_q];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pf_vld_q  <= 1'b0;
      m_val_q   <= 1'b0;
      m_data_q  <= '0;
      level_q   <= '0;
      s_rdy_q   <= 1'b1;
      hiwater_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pf_vld_q  <= pf_vld_d;
      m_val_q   <= m_val_d;
      m_data_q  <= m_data_d;
      level_q   <= level_d;
      s_rdy_q   <= s_rdy_d;
      hiwater_q <= hiwater_d;
      ovf_q     <= ovf_d;
    end
  end

  assign s_rdy   = s_rdy_q;
  assign m_val   = m_val_q;
  assign m_data  = m_data_q;
  assign level   = level_q;
  assign hiwater = hiwater_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_acm_rx_fifo.sv
// Directed bench for acm_rx_fifo with a queue model of accepted-but-unread bytes.
// Every edge is checked for level, hiwater, s_rdy, ovf and read data order.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_acm_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_val = 1'b0;
  logic       s_rdy;
  logic [7:0] m_data;
  logic       m_val;
  logic       m_rdy = 1'b0;
  logic [8:0] level;
  logic       hiwater;
  logic       ovf;

  acm_rx_fifo #(.DEPTH(256), .AW(8), .HIWATER(192)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_data(s_data), .s_val(s_val), .s_rdy(s_rdy),
    .m_data(m_data), .m_val(m_val), .m_rdy(m_rdy),
    .level(level), .hiwater(hiwater), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic [7:0] q[$];
  bit         movf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge: predict transfers from pre-edge state, then check post-edge outputs.
  task automatic step();
    bit         c, w, r;
    logic [7:0] wd, rb;
    c  = rst || flush;
    w  = !c && s_val && (q.size() < 256);
    r  = !c && (m_val === 1'b1) && m_rdy;
    wd = s_data;
    rb = m_data;
    if (!c && s_val && q.size() >= 256) movf = 1'b1;
    @(posedge clk);
    #1;
    if (c) begin
      q.delete();
      movf = 1'b0;
    end
    if (r) begin
      rd_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL rd_spurious: observed byte %0h expected no valid data", rb);
      end else begin
        chk("rd_data", 32'(rb), 32'(q.pop_front()));
      end
    end
    if (w) begin
      q.push_back(wd);
      wr_cnt++;
    end
    chk("level", 32'(level), 32'(q.size()));
    chk("hiwater", 32'(hiwater), 32'(q.size() >= 192));
    chk("s_rdy", 32'(s_rdy), 32'(q.size() < 256));
    chk("ovf", 32'(ovf), 32'(movf));
    if (q.size() == 0) chk("m_val_empty", 32'(m_val), 32'd0);
  endtask

  initial begin
    int  n;
    int  cyc;
    bit  done;
    logic [7:0] cnt;

    // Reset
    rst = 1'b1; s_val = 1'b1; s_data = 8'hEE; m_rdy = 1'b1;
    step();
    step();
    chk("rst_m_val", 32'(m_val), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_s_rdy", 32'(s_rdy), 32'd1);
    rst = 1'b0; s_val = 1'b0; m_rdy = 1'b0;
    step();

    // Single byte latency: accepted at edge N, visible after N+2
    s_val = 1'b1; s_data = 8'h41;
    step();
    s_val = 1'b0;
    chk("lat_n0_m_val", 32'(m_val), 32'd0);
    step();
    chk("lat_n1_m_val", 32'(m_val), 32'd0);
    step();
    chk("lat_n2_m_val", 32'(m_val), 32'd1);
    chk("lat_n2_m_data", 32'(m_data), 32'h41);
    chk("lat_n2_level", 32'(level), 32'd1);
    m_rdy = 1'b1;
    step();
    chk("lat_rd_level", 32'(level), 32'd0);
    chk("lat_rd_m_val", 32'(m_val), 32'd0);
    m_rdy = 1'b0;
    step();

    // Fill to full with 0x00..0xFF, reads stalled
    for (int i = 0; i < 256; i++) begin
      s_val = 1'b1; s_data = 8'(i);
      step();
      if (i == 190) chk("hiwater_191", 32'(hiwater), 32'd0);
      if (i == 191) chk("hiwater_192", 32'(hiwater), 32'd1);
    end
    chk("full_s_rdy", 32'(s_rdy), 32'd0);
    chk("full_level", 32'(level), 32'd256);

    // Hold at full with s_val high: ovf sets and sticks, nothing accepted
    s_data = 8'hAA;
    for (int i = 0; i < 4; i++) step();
    chk("full_ovf", 32'(ovf), 32'd1);
    chk("full_hold_level", 32'(level), 32'd256);

    // Drain at one byte per clock
    s_val = 1'b0; m_rdy = 1'b1;
    n = rd_cnt;
    step();
    chk("drain_s_rdy", 32'(s_rdy), 32'd1);
    for (int i = 1; i < 256; i++) step();
    chk("drain_rate", 32'(rd_cnt - n), 32'd256);
    chk("drain_level", 32'(level), 32'd0);
    step();
    step();
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // Simultaneous write and read for 1000 cycles with incrementing data
    cnt = 8'h00;
    s_val = 1'b1; m_rdy = 1'b1; s_data = cnt;
    for (int i = 0; i < 1000; i++) begin
      n = wr_cnt;
      step();
      if (wr_cnt != n) cnt = cnt + 8'd1;
      s_data = cnt;
    end
    chk("steady_level", 32'(level), 32'd3);
    s_val = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Random valid/ready over 10000 bytes
    n = wr_cnt + 10000;
    cyc = 0;
    while (wr_cnt < n && cyc < 60000) begin
      s_val  = 1'($urandom_range(0, 1));
      m_rdy  = 1'($urandom_range(0, 1));
      s_data = 8'($urandom);
      step();
      cyc++;
    end
    chk("rand_writes_done", 32'(wr_cnt >= n), 32'd1);
    s_val = 1'b0; m_rdy = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      step();
      if (q.size() == 0 && m_val === 1'b0) done = 1'b1;
    end
    chk("rand_drained", 32'(done), 32'd1);

    // Flush with 100 bytes held and ovf still set
    m_rdy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      s_val = 1'b1; s_data = 8'(i + 8'h30);
      step();
    end
    chk("pre_flush_level", 32'(level), 32'd100);
    flush = 1'b1; s_val = 1'b1; s_data = 8'hC3; m_rdy = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_m_val", 32'(m_val), 32'd0);
    chk("flush_m_data", 32'(m_data), 32'd0);
    chk("flush_s_rdy", 32'(s_rdy), 32'd1);
    chk("flush_ovf", 32'(ovf), 32'd0);
    m_rdy = 1'b0; s_data = 8'h5A;
    step();
    s_data = 8'h5B;
    step();
    s_val = 1'b0;
    step();
    step();
    chk("post_flush_first", 32'(m_data), 32'h5A);
    m_rdy = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Reset in the middle of a streaming burst
    s_val = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = 8'(8'h10 + i);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_m_val", 32'(m_val), 32'd0);
    chk("mid_rst_s_rdy", 32'(s_rdy), 32'd1);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    m_rdy = 1'b0; s_data = 8'h77;
    step();
    s_val = 1'b0;
    step();
    step();
    chk("post_rst_first", 32'(m_data), 32'h77);
    chk("post_rst_m_val", 32'(m_val), 32'd1);
    m_rdy = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
